// File: rtl/pipe_ctrl_defs.sv
// Shared definitions for the pipeline stall controller.
// State encodings plus the per-stage enable/flush bundle and its fixed patterns.
package pipe_ctrl_defs;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_flush;
    } pipe_ctl_t;

    // Frozen with bubbles in every flushable stage.
    localparam pipe_ctl_t CTL_INIT     = pipe_ctl_t'(8'b0010_1001);
    // Front end frozen, bubble into WB while memory is busy.
    localparam pipe_ctl_t CTL_MEM      = pipe_ctl_t'(8'b0000_0001);
    // Redirect: squash IF/ID and ID/EX, everything advances.
    localparam pipe_ctl_t CTL_BRANCH   = pipe_ctl_t'(8'b1111_1110);
    // Hold PC and IF/ID, inject bubble into EX.
    localparam pipe_ctl_t CTL_LOAD_USE = pipe_ctl_t'(8'b0001_1110);
    // Free flow.
    localparam pipe_ctl_t CTL_RUN      = pipe_ctl_t'(8'b1101_0110);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, sticks at all-ones.
// Ports: clk, rst (async high), inc (count enable), cnt (current value).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline register enable/bubble sequencer: reset hold, load-use stall,
// branch flush, dmem wait and dmem timeout trap.
// Ports: clk, rst (async high); hazard inputs load_use_hz, branch_taken,
// dmem_req, dmem_ready; per-stage *_en / *_flush; fault (sticky);
// state_o (debug); stall_cnt (saturating count of pc_en==0 cycles).
module pipeline_stall_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int RESET_HOLD  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_use_hz,
    input  logic                 branch_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_en,
    output logic                 idex_flush,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 memwb_flush,
    output logic                 fault,
    output logic [STATE_W-1:0]   state_o,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam int HOLD_W = (RESET_HOLD > 1) ?
                            $clog2(RESET_HOLD) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_INIT =
        HOLD_W'(RESET_HOLD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nx;
    pipe_ctl_t         ctl;
    logic              fault_c;

    // Mutually exclusive decode of the hazard priority chain.
    logic mem_sel;
    logic br_sel;
    logic lu_sel;
    logic go_sel;

    assign mem_sel = dmem_req & ~dmem_ready;
    assign br_sel  = ~mem_sel & branch_taken;
    assign lu_sel  = ~mem_sel & ~branch_taken & load_use_hz;
    assign go_sel  = ~mem_sel & ~branch_taken & ~load_use_hz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            hold_cnt <= HOLD_INIT;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        ctl      = CTL_RUN;
        fault_c  = 1'b0;
        state_nx = state;
        hold_nx  = hold_cnt;
        wait_nx  = wait_cnt;
        unique case (state)
            ST_INIT: begin
                ctl = CTL_INIT;
                if (hold_cnt == '0) begin
                    state_nx = ST_RUN;
                end else begin
                    hold_nx = hold_cnt - 1'b1;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                unique case (1'b1)
                    mem_sel: begin
                        ctl = CTL_MEM;
                        if (wait_cnt == WAIT_LAST) begin
                            state_nx = ST_FAULT;
                        end else begin
                            state_nx = ST_MEM_WAIT;
                            wait_nx  = wait_cnt + 1'b1;
                        end
                    end
                    br_sel: begin
                        ctl      = CTL_BRANCH;
                        state_nx = ST_RUN;
                        wait_nx  = '0;
                    end
                    lu_sel: begin
                        ctl      = CTL_LOAD_USE;
                        state_nx = ST_RUN;
                        wait_nx  = '0;
                    end
                    go_sel: begin
                        ctl      = CTL_RUN;
                        state_nx = ST_RUN;
                        wait_nx  = '0;
                    end
                    default: begin
                        ctl = CTL_RUN;
                    end
                endcase
            end
            ST_FAULT: begin
                ctl     = CTL_MEM;
                fault_c = 1'b1;
            end
            default: begin
                ctl = CTL_INIT;
            end
        endcase
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_en     = ctl.idex_en;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign memwb_flush = ctl.memwb_flush;
    assign fault       = fault_c;
    assign state_o     = state;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(~ctl.pc_en),
        .cnt(stall_cnt)
    );

endmodule
